// File: rtl/spi_oled_cmd_rx.sv
// spi_oled_cmd_rx : SPI receiver and SSD1306-style command decoder with GDDRAM pixel tagging.
// Revision 1.0
`default_nettype none

module spi_oled_cmd_rx #(
  parameter logic [7:0] CONTRAST_RST  = 8'h7F,
  parameter logic [7:0] PRECHARGE_RST = 8'h22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       mosi,
  input  logic       cs_n,
  input  logic       dc,
  output logic [7:0] contrast,
  output logic [7:0] precharge,
  output logic       charge_pump_en,
  output logic       display_on,
  output logic       entire_on,
  output logic       pix_valid,
  output logic [7:0] pix_byte,
  output logic [2:0] pix_page,
  output logic [6:0] pix_col,
  output logic       unknown_cmd,
  output logic       cmd_abort
);

  typedef enum logic [1:0] {S_OPCODE = 2'd0, S_ARG1 = 2'd1, S_ARG2 = 2'd2} state_t;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2, csn_s1, csn_s2, dc_s1, dc_s2;
  logic rise_q, mosi_q, dc_q;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       full, dc_last;
  logic       byte_done, dc_r;
  logic [7:0] byte_r;

  state_t     state;
  logic [7:0] opcode;
  logic [6:0] col_start, col_end, col_ptr;
  logic [2:0] page_start, page_end, page_ptr;

  wire rise = sclk_s2 & ~sclk_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
      {mosi_s1, mosi_s2, csn_s1, csn_s2, dc_s1, dc_s2} <= 6'b0;
      rise_q    <= 1'b0;
      mosi_q    <= 1'b0;
      dc_q      <= 1'b0;
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      full      <= 1'b0;
      dc_last   <= 1'b0;
      byte_done <= 1'b0;
      byte_r    <= 8'h00;
      dc_r      <= 1'b0;
    end else begin
      sclk_s1 <= spi_clk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
      mosi_s1 <= mosi;    mosi_s2 <= mosi_s1;
      csn_s1  <= cs_n;    csn_s2  <= csn_s1;
      dc_s1   <= dc;      dc_s2   <= dc_s1;

      rise_q <= rise & ~csn_s2;
      mosi_q <= mosi_s2;
      dc_q   <= dc_s2;

      // A deselect between edge capture and shift still drops the bit.
      full <= 1'b0;
      if (csn_s2) begin
        bit_cnt <= 3'd0;
      end else if (rise_q) begin
        shreg   <= {shreg[6:0], mosi_q};
        bit_cnt <= bit_cnt + 3'd1;
        full    <= (bit_cnt == 3'd7);
        dc_last <= dc_q;
      end

      byte_done <= full;
      byte_r    <= shreg;
      dc_r      <= dc_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_OPCODE;
      opcode         <= 8'h00;
      contrast       <= CONTRAST_RST;
      precharge      <= PRECHARGE_RST;
      charge_pump_en <= 1'b0;
      display_on     <= 1'b0;
      entire_on      <= 1'b0;
      col_start      <= 7'd0;
      col_end        <= 7'd127;
      page_start     <= 3'd0;
      page_end       <= 3'd7;
      col_ptr        <= 7'd0;
      page_ptr       <= 3'd0;
      pix_valid      <= 1'b0;
      pix_byte       <= 8'h00;
      pix_page       <= 3'd0;
      pix_col        <= 7'd0;
      unknown_cmd    <= 1'b0;
      cmd_abort      <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      unknown_cmd <= 1'b0;
      cmd_abort   <= 1'b0;
      if (byte_done) begin
        if (dc_r) begin
          if (state != S_OPCODE) cmd_abort <= 1'b1;
          state     <= S_OPCODE;
          pix_valid <= 1'b1;
          pix_byte  <= byte_r;
          pix_page  <= page_ptr;
          pix_col   <= col_ptr;
          // Horizontal addressing: wrap column to start, then step page.
          if (col_ptr == col_end) begin
            col_ptr  <= col_start;
            page_ptr <= (page_ptr == page_end) ? page_start : page_ptr + 3'd1;
          end else begin
            col_ptr <= col_ptr + 7'd1;
          end
        end else begin
          case (state)
            S_OPCODE: begin
              case (byte_r)
                8'h81, 8'hD9, 8'h8D, 8'h21, 8'h22: begin
                  opcode <= byte_r;
                  state  <= S_ARG1;
                end
                8'hAE:   display_on <= 1'b0;
                8'hAF:   display_on <= 1'b1;
                8'hA4:   entire_on  <= 1'b0;
                8'hA5:   entire_on  <= 1'b1;
                default: unknown_cmd <= 1'b1;
              endcase
            end
            S_ARG1: begin
              state <= S_OPCODE;
              case (opcode)
                8'h81: contrast       <= byte_r;
                8'hD9: precharge      <= byte_r;
                8'h8D: charge_pump_en <= byte_r[2];
                8'h21: begin col_start  <= byte_r[6:0]; state <= S_ARG2; end
                8'h22: begin page_start <= byte_r[2:0]; state <= S_ARG2; end
                default: ;
              endcase
            end
            S_ARG2: begin
              state <= S_OPCODE;
              if (opcode == 8'h21) begin
                col_end <= byte_r[6:0];
                col_ptr <= col_start;
              end else begin
                page_end <= byte_r[2:0];
                page_ptr <= page_start;
              end
            end
            default: state <= S_OPCODE;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/spi_oled_cmd_rx.md
Name: spi_oled_cmd_rx

Overview:
SPI receiver and SSD1306-style command decoder. It is the device-side counterpart of the OLED init/command transmitter. It oversamples spi_clk/mosi/cs_n/dc on the system clock, deserialises MSB-first bytes, parses the command stream into display-state registers, and emits GDDRAM data bytes tagged with auto-incremented page/column addresses. It is used as the on-chip display model for simulation and as an FPGA loopback checker.

Parameters:
CONTRAST_RST, 8'h7F, reset value of contrast register
PRECHARGE_RST, 8'h22, reset value of precharge register

Ports:
clk  in  1  system clock; must be >= 4x spi_clk, with each spi_clk phase >= 2 clk cycles
rst_n  in  1  reset, synchronous, active-low
spi_clk  in  1  serial clock, async; mosi sampled on its rising edge
mosi  in  1  serial data, MSB first
cs_n  in  1  chip select, active-low; high clears partial byte
dc  in  1  0 = command byte, 1 = data byte; sampled with bit 7 (last bit) of each byte
contrast  out  8  last 0x81 argument
precharge  out  8  last 0xD9 argument
charge_pump_en  out  1  bit 2 of last 0x8D argument
display_on  out  1  1 after 0xAF, 0 after 0xAE
entire_on  out  1  1 after 0xA5, 0 after 0xA4
pix_valid  out  1  one-cycle pulse per data byte
pix_byte  out  8  data byte
pix_page  out  3  page pointer for pix_byte
pix_col  out  7  column pointer for pix_byte
unknown_cmd  out  1  one-cycle pulse on unrecognised opcode
cmd_abort  out  1  one-cycle pulse when a data byte interrupts a pending argument

Behaviour:
- Input sync: 2-flop synchronisers on spi_clk, mosi, cs_n, dc, plus a 3rd spi_clk flop. Rising edge = sync2 & ~prev.
- Deserialiser: on each rising edge with synced cs_n low, shift mosi into an 8-bit register and increment a 3-bit bit counter. On the 8th bit, register byte_done plus the byte and dc for one cycle, and wrap the counter to 0.
- Synced cs_n high: bit counter is 0 and the partial byte is discarded. Parser state is retained.
- Latency: the parser acts in the cycle after byte_done. All outputs are registered. A register update or pulse appears exactly 5 clk edges after the first clk edge that samples spi_clk high for bit 7.
- Parser FSM states: OPCODE, ARG1, ARG2. The pending opcode is held in a register.
- OPCODE, command byte:
  - 0x81, 0xD9, 0x8D -> ARG1.
  - 0x21, 0x22 -> ARG1.
  - 0xAE/0xAF set display_on to 0/1; 0xA4/0xA5 set entire_on to 0/1. Stay in OPCODE.
  - Any other opcode: pulse unknown_cmd, stay in OPCODE.
- ARG1, command byte:
  - 0x81: contrast <= byte, then OPCODE.
  - 0xD9: precharge <= byte, then OPCODE.
  - 0x8D: charge_pump_en <= byte[2], then OPCODE.
  - 0x21: col_start <= byte[6:0], then ARG2.
  - 0x22: page_start <= byte[2:0], then ARG2.
- ARG2, command byte:
  - 0x21: col_end <= byte[6:0], col_ptr <= col_start, then OPCODE.
  - 0x22: page_end <= byte[2:0], page_ptr <= page_start, then OPCODE.
- Data byte (dc=1) in any state:
  - If state != OPCODE: pulse cmd_abort, discard pending args (already-written start value kept), go to OPCODE.
  - Then always emit pix_valid with pix_byte, pix_page = page_ptr, pix_col = col_ptr.
  - Pointer advance, horizontal mode: if col_ptr == col_end, col_ptr <= col_start and page_ptr <= (page_ptr == page_end) ? page_start : page_ptr+1. Otherwise col_ptr+1 (7-bit).
  - If start > end, pointers still increment modulo width until they equal end. No error.
- Reset values: contrast = CONTRAST_RST, precharge = PRECHARGE_RST, charge_pump_en 0, display_on 0, entire_on 0, col_start 0, col_end 127, page_start 0, page_end 7, col_ptr 0, page_ptr 0. pix_* outputs, unknown_cmd and cmd_abort are 0. FSM = OPCODE, bit counter 0, synchronisers 0.
- Reset mid-byte or mid-command: everything returns to reset values. No pulse is emitted for the interrupted byte.
- No byte may complete while cs_n is high. Bytes in flight are never merged across a cs_n high period.

Test Plan:
- Send 8D 14 81 CF D9 F1 A4 AF -> charge_pump_en=1, contrast=CF, precharge=F1, entire_on=0, display_on=1; no unknown_cmd or cmd_abort.
- Send 22 00 FF 21 00 7F, then 130 data bytes 0..129 -> pix_col 0..127 on page 0, then col 0,1 on page 1 (page_end=7); byte 128 tagged page 1 col 0.
- Window 21 10 12, 22 06 07, then 7 data bytes -> (page,col) = (6,10),(6,11),(6,12),(7,10),(7,11),(7,12),(6,10).
- Send 81 with dc=0, then data byte 55 with dc=1 -> cmd_abort pulse, contrast unchanged (7F), pix_valid with pix_byte=55; next command byte is decoded as an opcode.
- Send 5 bits, raise cs_n for 3 clk, then full byte AF -> display_on=1, no stray byte. Send opcode 3C -> single unknown_cmd pulse.
- Drop rst_n for 1 clk after 0x21 0x20 -> col_start=0, FSM in OPCODE, contrast=7F, all pulses low.
